// File: rtl/bulk_ep_in.sv
// rtl/bulk_ep_in.sv - bulk IN endpoint buffer: byte FIFO, packetizer, DATA0/1 toggle, retransmit on timeout
// Data between chk_ptr and rd_ptr stays in the FIFO until the host ACKs it.
module bulk_ep_in #(
  parameter int MAX_PACKET_SIZE = 512,
  parameter int FIFO_ABITS      = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_conf_i,
  input  logic       selected_i,
  input  logic       start_i,
  input  logic       ack_i,
  input  logic       timeout_i,
  output logic       ready_o,
  output logic       dtype_o,
  output logic       busy_o,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  input  logic       s_tlast_i,
  input  logic [7:0] s_tdata_i,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic [7:0] m_tdata_o
);

  localparam int PW    = FIFO_ABITS + 1;
  localparam int CW    = $clog2(MAX_PACKET_SIZE + 1);
  localparam int DEPTH = 2 ** FIFO_ABITS;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] MPS_P    = PW'(MAX_PACKET_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_PACKET_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK} state_e;

  logic [8:0]    mem [DEPTH];
  state_e        state_q;
  logic [PW-1:0] wr_q, rd_q, chk_q, tlast_cnt_q;
  logic [PW-1:0] wr_d, rd_d, chk_d, tlast_cnt_d, used_d;
  logic [CW-1:0] cnt_q;
  logic          last_tlast_q, ent_tlast_q;
  logic          ready_q, s_tready_q, dtype_q;
  logic          m_tvalid_q, m_tlast_q;
  logic [7:0]    m_tdata_q;
  logic          wr_en, start_ok, hs, do_ack, do_to, tl_inc, tl_dec;
  logic [8:0]    next_word;

  assign wr_en    = s_tvalid_i && s_tready_q;
  assign start_ok = (state_q == S_IDLE) && start_i && selected_i && ready_q;
  assign hs       = (state_q == S_SEND) && m_tvalid_q && m_tready_i;
  assign do_ack   = (state_q == S_WAIT_ACK) && ack_i;
  assign do_to    = (state_q == S_WAIT_ACK) && timeout_i && !ack_i;
  assign tl_inc   = wr_en && s_tlast_i;
  assign tl_dec   = do_ack && last_tlast_q;

  always_comb begin
    wr_d        = wr_en ? wr_q + PW'(1) : wr_q;
    rd_d        = do_to ? chk_q : (hs ? rd_q + PW'(1) : rd_q);
    chk_d       = do_ack ? rd_q : chk_q;
    tlast_cnt_d = tlast_cnt_q;
    if (tl_inc && !tl_dec) tlast_cnt_d = tlast_cnt_q + PW'(1);
    else if (!tl_inc && tl_dec) tlast_cnt_d = tlast_cnt_q - PW'(1);
    used_d      = wr_d - chk_d;
  end

  // Entry presented next: head of packet on entry to SEND, following byte after a handshake.
  assign next_word = mem[rd_d[FIFO_ABITS-1:0]];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_q[FIFO_ABITS-1:0]] <= {s_tlast_i, s_tdata_i};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      chk_q        <= '0;
      tlast_cnt_q  <= '0;
      cnt_q        <= '0;
      last_tlast_q <= 1'b0;
      ent_tlast_q  <= 1'b0;
      ready_q      <= 1'b0;
      s_tready_q   <= 1'b0;
      dtype_q      <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      chk_q       <= chk_d;
      tlast_cnt_q <= tlast_cnt_d;
      s_tready_q  <= (used_d != DEPTH_P);
      // A full packet is present whenever ready is high, so SEND never starves.
      ready_q     <= (used_d >= MPS_P) || (tlast_cnt_d != '0);
      if (set_conf_i) dtype_q <= 1'b0;
      else if (do_ack) dtype_q <= ~dtype_q;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q     <= S_SEND;
            cnt_q       <= '0;
            m_tvalid_q  <= 1'b1;
            m_tdata_q   <= next_word[7:0];
            ent_tlast_q <= next_word[8];
            m_tlast_q   <= next_word[8] || (LAST_IDX == '0);
          end
        end
        S_SEND: begin
          if (hs) begin
            if (m_tlast_q) begin
              state_q      <= S_WAIT_ACK;
              m_tvalid_q   <= 1'b0;
              m_tlast_q    <= 1'b0;
              last_tlast_q <= ent_tlast_q;
            end else begin
              cnt_q       <= cnt_q + CW'(1);
              m_tdata_q   <= next_word[7:0];
              ent_tlast_q <= next_word[8];
              m_tlast_q   <= next_word[8] || (cnt_q + CW'(1) == LAST_IDX);
            end
          end
        end
        S_WAIT_ACK: begin
          if (ack_i || timeout_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign dtype_o    = dtype_q;
  assign busy_o     = (state_q != S_IDLE);
  assign s_tready_o = s_tready_q;
  assign m_tvalid_o = m_tvalid_q;
  assign m_tlast_o  = m_tlast_q;
  assign m_tdata_o  = m_tdata_q;

endmodule
